// File: rtl/axis_rr_pkt_arbiter_4to1.sv
`default_nettype none
// ============================================================================
// axis_rr_pkt_arbiter_4to1 : packet-granular 4:1 round-robin AXI4-Stream merge
// Rev 1.0
// ============================================================================
module axis_rr_pkt_arbiter_4to1 #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_STAMP_SRC_PORT   = 1,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [4*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [4*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [4*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [3:0]                        s_axis_tvalid,
  output logic [3:0]                        s_axis_tready,
  input  logic [3:0]                        s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [4*C_CNT_WIDTH-1:0]          pkt_cnt
);

  localparam int W = C_AXIS_DATA_WIDTH;
  localparam int S = C_AXIS_DATA_WIDTH / 8;
  localparam int U = C_AXIS_TUSER_WIDTH;
  localparam int C = C_CNT_WIDTH;

  typedef enum logic [0:0] {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t         state;
  logic [1:0]     grant;
  logic [1:0]     last_grant;
  logic [1:0]     next_grant;
  logic [C-1:0]   cnt [4];
  logic           pkt_done;

  // Descending scan so the closest input after last_grant wins.
  always_comb begin
    next_grant = last_grant;
    for (int k = 4; k >= 1; k--) begin
      if (s_axis_tvalid[last_grant + 2'(k)]) begin
        next_grant = last_grant + 2'(k);
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (state == PKT) begin
      m_axis_tdata  = s_axis_tdata[int'(grant)*W +: W];
      m_axis_tstrb  = s_axis_tstrb[int'(grant)*S +: S];
      m_axis_tuser  = s_axis_tuser[int'(grant)*U +: U];
      m_axis_tvalid = s_axis_tvalid[grant];
      m_axis_tlast  = s_axis_tlast[grant];
      if (C_STAMP_SRC_PORT != 0) begin
        m_axis_tuser[23:16] = 8'd1 << {grant, 1'b0};
      end
      s_axis_tready[grant] = m_axis_tready;
    end
  end

  assign pkt_done = (state == PKT) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd3;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (|s_axis_tvalid) begin
            grant <= next_grant;
            state <= PKT;
          end
        end
        PKT: begin
          // Grant is held through source bubbles until the tlast handshake.
          if (pkt_done) begin
            last_grant <= grant;
            cnt[grant] <= cnt[grant] + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    assign pkt_cnt[i*C +: C] = cnt[i];
  end

endmodule
`default_nettype wire
